// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: classifies, numbers and queues retired instructions.
// Optional build macro TRACE_FILTER_NOP_EN keeps NOP records out of the FIFO.
module retire_trace_buf #(
  parameter int DEPTH      = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [2:0]  trc_kind,
  output logic [31:0] trc_inum,
  output logic [15:0] trc_pc,
  output logic [3:0]  trc_reg,
  output logic [15:0] trc_addr,
  output logic [15:0] trc_value,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic        halted,
  output logic        timeout,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] KIND_NOP   = 3'd0;
  localparam logic [2:0] KIND_REG   = 3'd1;
  localparam logic [2:0] KIND_LOAD  = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_HALT  = 3'd4;

  localparam logic [31:0] WDOG_LAST = 32'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  regNum;
    logic [15:0] addr;
    logic [15:0] value;
  } traceRec_t;

  traceRec_t fifoMem [DEPTH];
  traceRec_t newRec;
  traceRec_t headRec;

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] fifoCount;

  logic [31:0] instCount;
  logic [31:0] cycleCount;
  logic        haltedQ;
  logic        timeoutQ;
  logic        overflowQ;
  logic [15:0] dropCount;

  logic active;
  logic isLoad;
  logic isReg;
  logic isHalt;
  logic isStore;
  logic isNop;
  logic wantPush;
  logic doPush;
  logic doPop;
  logic doDrop;
  logic fifoFull;
  logic fifoValid;
  logic wdogHit;

  assign active = ~haltedQ & ~timeoutQ;

  // One-hot decode of the priority order LOAD > REG > HALT > STORE > NOP.
  assign isLoad  = reg_write & mem_read;
  assign isReg   = reg_write & ~mem_read;
  assign isHalt  = ~reg_write & hlt;
  assign isStore = ~reg_write & ~hlt & mem_write;
  assign isNop   = ~reg_write & ~hlt & ~mem_write;

  always_comb begin
    newRec      = '0;
    newRec.inum = instCount;
    newRec.pc   = pc;
    unique case (1'b1)
      isLoad: begin
        newRec.kind   = KIND_LOAD;
        newRec.regNum = write_reg;
        newRec.addr   = mem_addr;
        newRec.value  = write_data;
      end
      isReg: begin
        newRec.kind   = KIND_REG;
        newRec.regNum = write_reg;
        newRec.value  = write_data;
      end
      isHalt: begin
        newRec.kind = KIND_HALT;
      end
      isStore: begin
        newRec.kind  = KIND_STORE;
        newRec.addr  = mem_addr;
        newRec.value = mem_data;
      end
      default: begin
        newRec.kind = KIND_NOP;
      end
    endcase
  end

`ifdef TRACE_FILTER_NOP_EN
  assign wantPush = active & ~isNop;
`else
  assign wantPush = active;
`endif

  assign fifoValid = fifoCount != '0;
  assign fifoFull  = fifoCount == FULL_CNT;
  assign doPop     = fifoValid & trc_ready;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign doPush    = wantPush & (~fifoFull | doPop);
  assign doDrop    = wantPush & ~doPush;
  assign wdogHit   = active & ~isHalt & (cycleCount == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      fifoCount <= fifoCount + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      fifoMem[wrPtr] <= newRec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instCount  <= '0;
      cycleCount <= '0;
    end else if (active) begin
      instCount  <= instCount + 32'd1;
      cycleCount <= cycleCount + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      haltedQ  <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      if (active && isHalt) begin
        haltedQ <= 1'b1;
      end
      if (wdogHit) begin
        timeoutQ <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflowQ <= 1'b0;
      dropCount <= '0;
    end else if (doDrop) begin
      overflowQ <= 1'b1;
      if (dropCount != DROP_MAX) begin
        dropCount <= dropCount + 16'd1;
      end
    end
  end

  // Stale RAM contents never reach the port: fields read zero when empty.
  assign headRec = fifoMem[rdPtr];

  assign trc_valid = fifoValid;
  assign trc_kind  = fifoValid ? headRec.kind   : '0;
  assign trc_inum  = fifoValid ? headRec.inum   : '0;
  assign trc_pc    = fifoValid ? headRec.pc     : '0;
  assign trc_reg   = fifoValid ? headRec.regNum : '0;
  assign trc_addr  = fifoValid ? headRec.addr   : '0;
  assign trc_value = fifoValid ? headRec.value  : '0;

  assign inst_count  = instCount;
  assign cycle_count = cycleCount;
  assign halted      = haltedQ;
  assign timeout     = timeoutQ;
  assign overflow    = overflowQ;
  assign drop_count  = dropCount;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Bench for retire_trace_buf: vector table, corner sequences, random vs queue model.
// A second instance with a short watchdog limit covers the timeout path.
module tb_retire_trace_buf;

  localparam int DEPTH = 8;
  localparam int MAXC  = 100000;
  localparam int MAXB  = 20;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] pc;
  logic reg_write;
  logic [3:0] write_reg;
  logic [15:0] write_data;
  logic mem_read;
  logic mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic hlt;
  logic trc_ready;

  logic trcValid;
  logic [2:0] trcKind;
  logic [31:0] trcInum;
  logic [15:0] trcPc;
  logic [3:0] trcReg;
  logic [15:0] trcAddr;
  logic [15:0] trcValue;
  logic [31:0] instCount;
  logic [31:0] cycleCount;
  logic halted;
  logic timeout;
  logic overflow;
  logic [15:0] dropCount;

  logic bValid;
  logic [2:0] bKind;
  logic [31:0] bInum;
  logic [15:0] bPc;
  logic [3:0] bReg;
  logic [15:0] bAddr;
  logic [15:0] bValue;
  logic [31:0] bInst;
  logic [31:0] bCycle;
  logic bHalted;
  logic bTimeout;
  logic bOverflow;
  logic [15:0] bDrop;

  int nTests = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  retire_trace_buf #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
    .trc_valid(trcValid), .trc_ready(trc_ready),
    .trc_kind(trcKind), .trc_inum(trcInum), .trc_pc(trcPc),
    .trc_reg(trcReg), .trc_addr(trcAddr), .trc_value(trcValue),
    .inst_count(instCount), .cycle_count(cycleCount),
    .halted(halted), .timeout(timeout), .overflow(overflow),
    .drop_count(dropCount)
  );

  retire_trace_buf #(.DEPTH(DEPTH), .MAX_CYCLES(MAXB)) dutB (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
    .trc_valid(bValid), .trc_ready(trc_ready),
    .trc_kind(bKind), .trc_inum(bInum), .trc_pc(bPc),
    .trc_reg(bReg), .trc_addr(bAddr), .trc_value(bValue),
    .inst_count(bInst), .cycle_count(bCycle),
    .halted(bHalted), .timeout(bTimeout), .overflow(bOverflow),
    .drop_count(bDrop)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] addr;
    logic [15:0] value;
  } rec_t;

  rec_t mq[$];
  logic [31:0] mInst;
  logic [31:0] mCyc;
  logic mHalt;
  logic mTo;
  logic mOvf;
  logic [15:0] mDrop;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a record queue plus counters, one retirement per live cycle.
  task automatic modelStep();
    rec_t r;
    bit pop;
    bit want;
    bit push;
    if (rst) begin
      mq.delete();
      mInst = 0; mCyc = 0; mHalt = 0; mTo = 0;
      mOvf = 0; mDrop = 0;
      return;
    end
    pop = (mq.size() != 0) && trc_ready;
    push = 0;
    if (!mHalt && !mTo) begin
      r = '{3'd0, mInst, pc, 4'd0, 16'd0, 16'd0};
      if (reg_write && mem_read) begin
        r.kind = 2; r.rg = write_reg; r.addr = mem_addr; r.value = write_data;
      end else if (reg_write) begin
        r.kind = 1; r.rg = write_reg; r.value = write_data;
      end else if (hlt) begin
        r.kind = 4;
      end else if (mem_write) begin
        r.kind = 3; r.addr = mem_addr; r.value = mem_data;
      end
      want = 1;
`ifdef TRACE_FILTER_NOP_EN
      want = (r.kind != 0);
`endif
      if (want) begin
        if (mq.size() < DEPTH || pop) push = 1;
        else begin
          mOvf = 1;
          if (mDrop != 16'hFFFF) mDrop++;
        end
      end
      if (mCyc == 32'(MAXC - 1) && r.kind != 4) mTo = 1;
      if (r.kind == 4) mHalt = 1;
      mInst++;
      mCyc++;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(r);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic compareModel(string tag);
    rec_t h;
    h = '{3'd0, 32'd0, 16'd0, 4'd0, 16'd0, 16'd0};
    if (mq.size() != 0) h = mq[0];
    chk({tag, ".valid"}, 32'(trcValid), 32'(mq.size() != 0));
    chk({tag, ".kind"}, 32'(trcKind), 32'(h.kind));
    chk({tag, ".inum"}, trcInum, h.inum);
    chk({tag, ".pc"}, 32'(trcPc), 32'(h.pc));
    chk({tag, ".reg"}, 32'(trcReg), 32'(h.rg));
    chk({tag, ".addr"}, 32'(trcAddr), 32'(h.addr));
    chk({tag, ".value"}, 32'(trcValue), 32'(h.value));
    chk({tag, ".inst"}, instCount, mInst);
    chk({tag, ".cycle"}, cycleCount, mCyc);
    chk({tag, ".halted"}, 32'(halted), 32'(mHalt));
    chk({tag, ".timeout"}, 32'(timeout), 32'(mTo));
    chk({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
    chk({tag, ".drops"}, 32'(dropCount), 32'(mDrop));
  endtask

  task automatic zeroIn();
    pc = 0; reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0; hlt = 0;
  endtask

  task automatic doReset();
    zeroIn();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic rs; logic [15:0] p; logic rw; logic [3:0] wr; logic [15:0] wd;
    logic mr; logic mw; logic [15:0] ma; logic [15:0] md; logic hl; logic rdy;
    logic eV; logic [2:0] eK; logic [31:0] eI; logic [15:0] eP;
    logic [3:0] eR; logic [15:0] eA; logic [15:0] eD;
  } vec_t;

  function automatic vec_t mk(
    logic rs, logic [15:0] p, logic rw, logic [3:0] wr, logic [15:0] wd,
    logic mr, logic mw, logic [15:0] ma, logic [15:0] md, logic hl, logic rdy,
    logic eV, logic [2:0] eK, logic [31:0] eI, logic [15:0] eP,
    logic [3:0] eR, logic [15:0] eA, logic [15:0] eD);
    vec_t v;
    v = '{rs, p, rw, wr, wd, mr, mw, ma, md, hl, rdy,
          eV, eK, eI, eP, eR, eA, eD};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1;
    trc_ready = 0;
    zeroIn();

    // rst pc rw wr wd mr mw ma md hl rdy | valid kind inum pc reg addr value
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 3, 16'h00AB, 0, 0, 0, 0, 0, 1,
                     1, 1, 0, 16'h0000, 3, 0, 16'h00AB));
    tbl.push_back(mk(0, 16'h0002, 0, 0, 0, 0, 1, 16'h0010, 16'hBEEF, 0, 1,
                     1, 3, 1, 16'h0002, 0, 16'h0010, 16'hBEEF));
    tbl.push_back(mk(0, 16'h0004, 1, 5, 16'h1234, 1, 0, 16'h0010, 0, 0, 1,
                     1, 2, 2, 16'h0004, 5, 16'h0010, 16'h1234));
    tbl.push_back(mk(0, 16'h0006, 1, 1, 16'h0055, 0, 0, 0, 0, 0, 1,
                     1, 1, 3, 16'h0006, 1, 0, 16'h0055));
`ifdef TRACE_FILTER_NOP_EN
    tbl.push_back(mk(0, 16'h0008, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 0, 0, 0, 0, 0));
`else
    tbl.push_back(mk(0, 16'h0008, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 0, 4, 16'h0008, 0, 0, 0));
`endif
    tbl.push_back(mk(0, 16'h000A, 1, 2, 16'h0077, 0, 0, 0, 0, 0, 1,
                     1, 1, 5, 16'h000A, 2, 0, 16'h0077));
    tbl.push_back(mk(0, 16'h000C, 1, 7, 16'h0099, 0, 1, 16'h0030, 16'h0044, 0, 1,
                     1, 1, 6, 16'h000C, 7, 0, 16'h0099));
    tbl.push_back(mk(0, 16'h000E, 1, 8, 16'h0011, 0, 0, 0, 0, 0, 0,
                     1, 1, 6, 16'h000C, 7, 0, 16'h0099));

    foreach (tbl[i]) begin
      rst = tbl[i].rs; pc = tbl[i].p; reg_write = tbl[i].rw;
      write_reg = tbl[i].wr; write_data = tbl[i].wd;
      mem_read = tbl[i].mr; mem_write = tbl[i].mw;
      mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      hlt = tbl[i].hl; trc_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(trcValid), 32'(tbl[i].eV));
      chk($sformatf("vec%0d.kind", i), 32'(trcKind), 32'(tbl[i].eK));
      chk($sformatf("vec%0d.inum", i), trcInum, tbl[i].eI);
      chk($sformatf("vec%0d.pc", i), 32'(trcPc), 32'(tbl[i].eP));
      chk($sformatf("vec%0d.reg", i), 32'(trcReg), 32'(tbl[i].eR));
      chk($sformatf("vec%0d.addr", i), 32'(trcAddr), 32'(tbl[i].eA));
      chk($sformatf("vec%0d.value", i), 32'(trcValue), 32'(tbl[i].eD));
      compareModel("vecModel");
    end

    // Fill with consumer stalled: 8 held, 2 dropped.
    doReset();
    compareModel("afterReset");
    trc_ready = 0;
    for (int i = 0; i < 10; i++) begin
      zeroIn();
      reg_write = 1; write_reg = 4'(i); write_data = 16'(i); pc = 16'(2 * i);
      tick();
      compareModel("fill");
    end
    chk("fill.drops", 32'(dropCount), 2);
    chk("fill.overflow", 32'(overflow), 1);
    chk("fill.headInum", trcInum, 0);

    // Drain while still pushing: pop+push on a full FIFO never drops.
    for (int i = 0; i < 8; i++) begin
      zeroIn();
      reg_write = 1; pc = 16'(16'h0100 + i); trc_ready = 1;
      tick();
      compareModel("drain");
      chk("drain.headInum", trcInum, (i < 7) ? 32'(i + 1) : 32'd10);
      chk("drain.drops", 32'(dropCount), 2);
      chk("drain.valid", 32'(trcValid), 1);
    end

    // Halt then further retirements: nothing new, counters frozen.
    zeroIn();
    hlt = 1; pc = 16'h0020; trc_ready = 1;
    tick();
    compareModel("halt");
    chk("halt.halted", 32'(halted), 1);
    chk("halt.inst", instCount, 19);
    for (int j = 0; j < 9; j++) begin
      zeroIn();
      reg_write = 1; write_reg = 4'd9; pc = 16'(16'h0200 + j); trc_ready = 1;
      tick();
      compareModel("postHalt");
      if (j == 6) begin
        chk("postHalt.kind", 32'(trcKind), 4);
        chk("postHalt.pc", 32'(trcPc), 32'h20);
        chk("postHalt.inum", trcInum, 18);
      end
    end
    chk("postHalt.valid", 32'(trcValid), 0);
    chk("postHalt.inst", instCount, 19);
    chk("postHalt.cycle", cycleCount, 19);

    // Watchdog on the short-limit instance, NOP-only stimulus.
    doReset();
    trc_ready = 1;
    for (int c = 1; c <= 25; c++) begin
      zeroIn();
      pc = 16'(2 * c);
      tick();
      compareModel("wdog");
      if (c == MAXB - 1) chk("wdogB.earlyTimeout", 32'(bTimeout), 0);
      if (c == MAXB) begin
        chk("wdogB.timeout", 32'(bTimeout), 1);
        chk("wdogB.cycle", bCycle, 20);
      end
    end
    chk("wdogB.cycleFrozen", bCycle, 20);
    chk("wdogB.inst", bInst, 20);
    chk("wdogB.drops", 32'(bDrop), 0);
    chk("wdogB.valid", 32'(bValid), 0);
    chk("wdogB.halted", 32'(bHalted), 0);

    // Random traffic against the queue model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = (n / 200) % 3;
      rst = ($urandom_range(0, 59) == 0);
      pc = 16'($urandom);
      reg_write = ($urandom_range(0, 2) == 0);
      write_reg = 4'($urandom);
      write_data = 16'($urandom);
      mem_read = 1'($urandom_range(0, 1));
      mem_write = ($urandom_range(0, 2) == 0);
      mem_addr = 16'($urandom);
      mem_data = 16'($urandom);
      hlt = ($urandom_range(0, 39) == 0);
      if (bias == 0) trc_ready = ($urandom_range(0, 3) == 0);
      else if (bias == 1) trc_ready = ($urandom_range(0, 3) != 0);
      else trc_ready = 1;
      tick();
      compareModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
